// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter in front of the native memory bus.
// Allows one outstanding transfer at a time, with one idle cycle between owners.
// Optional bus-hang timeout is enabled by defining MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t      state;
  logic        last;
  logic        own0;
  logic        own1;
  logic        timeout;
  logic        complete;
  logic [31:0] rdata_sel;

  assign own0     = (state == OWN0);
  assign own1     = (state == OWN1);
  assign grant    = {own1, own0};
  assign s_valid  = (own0 & m0_valid) | (own1 & m1_valid);

  // Downstream request mux follows the registered owner, so it cannot change mid-transfer
  always_comb begin
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    s_wstrb = 4'd0;
    if (own0) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (own1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
  end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // s_ready has priority: a slave answering on the expiry cycle completes normally
  assign timeout = s_valid & ~s_ready & (wait_cnt == CNT_MAX);

  // Wait-cycle counter: held at zero while idle so every ownership starts fresh, saturates at max
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (s_valid && !s_ready && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign bus_err   = timeout;
  assign complete  = s_valid & (s_ready | timeout);
  assign rdata_sel = timeout ? ERR_RDATA : s_rdata;
  assign m0_ready  = own0 & complete;
  assign m1_ready  = own1 & complete;
  assign m0_rdata  = own0 ? rdata_sel : 32'd0;
  assign m1_rdata  = own1 ? rdata_sel : 32'd0;

  // Ownership FSM: round-robin on ties, back to IDLE on completion, timeout or master abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && (!m1_valid || last)) begin
            state <= OWN0;
          end else if (m1_valid) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!m0_valid) begin
            state <= IDLE;
          end else if (complete) begin
            state <= IDLE;
            last  <= 1'b0;
          end
        end
        OWN1: begin
          if (!m1_valid) begin
            state <= IDLE;
          end else if (complete) begin
            state <= IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, bus_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single m0 read, zero-wait slave
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 4'h0; s_ready = 1; s_rdata = 32'h12345678;
    #1;
    chk("t1_req_s_valid", 32'(s_valid), 32'd0);
    chk("t1_req_grant", 32'(grant), 32'd0);
    @(negedge clk); #1;
    chk("t1_s_valid", 32'(s_valid), 32'd1);
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_m0_ready", 32'(m0_ready), 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'h12345678);
    chk("t1_s_addr", s_addr, 32'h10);
    chk("t1_s_wstrb", 32'(s_wstrb), 32'd0);
    chk("t1_m1_ready", 32'(m1_ready), 32'd0);
    chk("t1_m1_rdata", m1_rdata, 32'd0);
    @(negedge clk);
    m0_valid = 0;
    #1;
    chk("t1_after_grant", 32'(grant), 32'd0);
    chk("t1_after_ready", 32'(m0_ready), 32'd0);

    // Both masters requesting continuously after a fresh reset: alternate, 2 cycles each
    reset_n = 1'b0; #1; reset_n = 1'b1;
    m0_valid = 1; m0_addr = 32'hA0; m1_valid = 1; m1_addr = 32'hB0; s_ready = 1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk($sformatf("t2_grant_%0d", k), 32'(grant),
          (k % 2 == 0) ? 32'd0 : ((k % 4 == 1) ? 32'd1 : 32'd2));
      chk($sformatf("t2_m0_ready_%0d", k), 32'(m0_ready), (k % 4 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t2_m1_ready_%0d", k), 32'(m1_ready), (k % 4 == 3) ? 32'd1 : 32'd0);
      if (k % 4 == 1) chk($sformatf("t2_s_addr_%0d", k), s_addr, 32'hA0);
      if (k % 4 == 3) chk($sformatf("t2_s_addr_%0d", k), s_addr, 32'hB0);
    end
    @(negedge clk);
    m0_valid = 0; m1_valid = 0;
    #1;
    chk("t2_end_grant", 32'(grant), 32'd0);

    // m1 write, slave answers after 3 wait cycles
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'hF0001000; m1_wdata = 32'h5A; m1_wstrb = 4'hF; s_ready = 0;
    #1;
    chk("t3_req_s_valid", 32'(s_valid), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) s_ready = 1;
      #1;
      chk($sformatf("t3_s_valid_%0d", c), 32'(s_valid), 32'd1);
      chk($sformatf("t3_s_addr_%0d", c), s_addr, 32'hF0001000);
      chk($sformatf("t3_s_wdata_%0d", c), s_wdata, 32'h5A);
      chk($sformatf("t3_s_wstrb_%0d", c), 32'(s_wstrb), 32'hF);
      chk($sformatf("t3_grant_%0d", c), 32'(grant), 32'd2);
      chk($sformatf("t3_m1_ready_%0d", c), 32'(m1_ready), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t3_m0_ready_%0d", c), 32'(m0_ready), 32'd0);
      chk($sformatf("t3_bus_err_%0d", c), 32'(bus_err), 32'd0);
    end
    @(negedge clk);
    m1_valid = 0;
    #1;
    chk("t3_after_s_valid", 32'(s_valid), 32'd0);
    chk("t3_after_m1_ready", 32'(m1_ready), 32'd0);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // m0 read against a hung slave: error completion on the 8th s_valid cycle
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h20; m0_wstrb = 4'h0; s_ready = 0;
    #1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      chk($sformatf("t4_s_valid_%0d", c), 32'(s_valid), 32'd1);
      chk($sformatf("t4_m0_ready_%0d", c), 32'(m0_ready), (c == 8) ? 32'd1 : 32'd0);
      chk($sformatf("t4_bus_err_%0d", c), 32'(bus_err), (c == 8) ? 32'd1 : 32'd0);
      if (c == 8) chk("t4_m0_rdata", m0_rdata, 32'hDEADBEEF);
    end
`else
    // m0 read with a long wait: no timeout exists, completion only on s_ready
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h20; m0_wstrb = 4'h0; s_ready = 0; s_rdata = 32'hCAFEF00D;
    #1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 12) s_ready = 1;
      #1;
      chk($sformatf("t4_s_valid_%0d", c), 32'(s_valid), 32'd1);
      chk($sformatf("t4_m0_ready_%0d", c), 32'(m0_ready), (c == 12) ? 32'd1 : 32'd0);
      chk($sformatf("t4_bus_err_%0d", c), 32'(bus_err), 32'd0);
      if (c == 12) chk("t4_m0_rdata", m0_rdata, 32'hCAFEF00D);
    end
`endif
    @(negedge clk);
    m0_valid = 0; s_ready = 0;
    #1;
    chk("t4_after_grant", 32'(grant), 32'd0);

    // m0 aborts mid-wait while m1 is pending; m1 gets the bus next
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h30;
    #1;
    chk("t6_req_grant", 32'(grant), 32'd0);
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'h40;
    #1;
    chk("t6_own_grant", 32'(grant), 32'd1);
    chk("t6_own_s_addr", s_addr, 32'h30);
    @(negedge clk); #1;
    chk("t6_wait_grant", 32'(grant), 32'd1);
    chk("t6_wait_m1_ready", 32'(m1_ready), 32'd0);
    @(negedge clk);
    m0_valid = 0;
    #1;
    chk("t6_abort_s_valid", 32'(s_valid), 32'd0);
    chk("t6_abort_m0_ready", 32'(m0_ready), 32'd0);
    @(negedge clk); #1;
    chk("t6_idle_grant", 32'(grant), 32'd0);
    @(negedge clk); #1;
    chk("t6_m1_grant", 32'(grant), 32'd2);
    chk("t6_m1_s_addr", s_addr, 32'h40);

    // Reset during the m1 wait state, then a tie goes to m0
    @(negedge clk); #1;
    chk("t5_wait_grant", 32'(grant), 32'd2);
    #1;
    reset_n = 1'b0; s_ready = 1;
    #1;
    chk("t5_rst_s_valid", 32'(s_valid), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_m1_ready", 32'(m1_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; m0_valid = 1; m0_addr = 32'h50;
    #1;
    chk("t5_rel_grant", 32'(grant), 32'd0);
    @(negedge clk); #1;
    chk("t5_tie_grant", 32'(grant), 32'd1);
    chk("t5_tie_m0_ready", 32'(m0_ready), 32'd1);
    chk("t5_tie_m1_ready", 32'(m1_ready), 32'd0);
    @(negedge clk);
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
